// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode constants, queue payload type and helpers.
package fetch_unit_pkg;

    localparam int unsigned PC_WIDTH         = 12;
    localparam int unsigned INSTR_WIDTH      = 32;
    localparam int unsigned FQ_DEPTH_DEFAULT = 4;

    localparam logic [PC_WIDTH-1:0]    PC_STEP    = PC_WIDTH'(4);
    localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = INSTR_WIDTH'(0);

    // Major opcodes shared with decode
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // One fetch-queue entry: instruction and the PC it was fetched from
    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fq_entry_t;

    localparam int unsigned FQ_WIDTH = $bits(fq_entry_t);

    // End-of-program sentinel detection
    function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] word);
        return word == HALT_INSTR;
    endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO with a registered head output that holds when empty.
module fetch_queue #(
    parameter int unsigned WIDTH = 44,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CNT_W-1:0] remain;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = dout_q;

    // Pointer/count update; head register loads the next head, bypassing din when it lands in an empty slot
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        dout_d   = dout_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        remain   = count_q - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (count_d != '0) begin
            dout_d = (do_push && remain == '0) ? din : mem_q[rd_ptr_d];
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, credit-checked imem requests, sentinel halt, fetch queue toward decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [PC_WIDTH-1:0]    dec_pc,
    output logic [INSTR_WIDTH-1:0] dec_instr,
    output logic                   halted
);

    localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                inflight_q, inflight_d;
    logic                halted_q, halted_d;
    logic                issue_c;
    logic                credit_ok;

    logic [CNT_W-1:0]    fq_count;
    logic                fq_full;
    logic                fq_empty;
    logic                fq_push;
    logic                fq_pop;
    fq_entry_t           fq_din;
    fq_entry_t           fq_dout;

    // Issue, response and halt decisions; the inflight slot is reserved so a response always fits
    always_comb begin
        credit_ok  = (fq_count + CNT_W'(inflight_q)) < CNT_W'(FQ_DEPTH);
        issue_c    = ~rst & fetch_en & ~halted_q & credit_ok;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue_c;
        halted_d   = halted_q | (inflight_q & is_halt(imem_rdata));
        fq_push    = inflight_q & ~halted_q & ~is_halt(imem_rdata) & (~fq_full | fq_pop);
        fq_pop     = ~fq_empty & dec_ready;
        fq_din     = '{pc: req_pc_q, instr: imem_rdata};
        if (issue_c) begin
            pc_d     = pc_q + PC_STEP;
            req_pc_d = pc_q;
        end
    end

    // Fetch control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            halted_q   <= halted_d;
        end
    end

    fetch_queue #(
        .WIDTH (FQ_WIDTH),
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk   (clk),
        .rst   (rst),
        .push  (fq_push),
        .pop   (fq_pop),
        .din   (fq_din),
        .dout  (fq_dout),
        .count (fq_count),
        .full  (fq_full),
        .empty (fq_empty)
    );

    assign imem_req  = issue_c;
    assign imem_addr = pc_q;
    assign dec_valid = ~fq_empty;
    assign dec_pc    = fq_dout.pc;
    assign dec_instr = fq_dout.instr;
    assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a 1-cycle imem model and a stream monitor.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [11:0] dec_pc;
    logic [31:0] dec_instr;
    logic        halted;

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] ADD  = 32'h0020_81B3;
    localparam logic [31:0] LW   = 32'h0000_A203;
    localparam logic [31:0] SW   = 32'h0040_A223;

    logic [31:0] imem [1024];

    int checks;
    int failures;

    // monitor state
    logic        mon_clr;
    int          req_cnt, pop_cnt, pop_bad, instr_bad, iss_bad, max_cnt;
    logic [11:0] max_addr, exp_iss, exp_pop, prev_addr;
    logic        wrap_seen;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_pc     (dec_pc),
        .dec_instr  (dec_instr),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: data for a request appears the following cycle
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem[imem_addr[11:2]];
    end

    // Stream monitor: issue order, pop order, payload and occupancy, sampled mid-cycle
    always begin
        @(negedge clk);
        #1;
        if (mon_clr) begin
            req_cnt = 0; pop_cnt = 0; pop_bad = 0; instr_bad = 0; iss_bad = 0; max_cnt = 0;
            max_addr = '0; exp_iss = '0; exp_pop = '0; prev_addr = '0; wrap_seen = 1'b0;
        end else if (!rst) begin
            if (imem_req) begin
                if (imem_addr != exp_iss) iss_bad++;
                if (req_cnt != 0 && prev_addr == 12'hFFC && imem_addr == 12'h000) wrap_seen = 1'b1;
                if (imem_addr > max_addr) max_addr = imem_addr;
                prev_addr = imem_addr;
                exp_iss   = imem_addr + 12'd4;
                req_cnt++;
            end
            if (dec_valid && dec_ready) begin
                if (dec_pc != exp_pop) pop_bad++;
                if (dec_instr != imem[dec_pc[11:2]]) instr_bad++;
                exp_pop = exp_pop + 12'd4;
                pop_cnt++;
            end
            if (int'(dut.fq_count) > max_cnt) max_cnt = int'(dut.fq_count);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill_all();
        for (int i = 0; i < 1024; i++) imem[i] = 32'h1000_0000 | 32'(i);
    endtask

    // Hold reset two cycles; returns at the negedge where reset releases (cycle 0)
    task automatic do_reset();
        rst = 1'b1;
        mon_clr = 1'b1;
        tick();
        tick();
        mon_clr = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        mon_clr = 1'b1;
        fetch_en = 1'b1;
        dec_ready = 1'b0;
        fill_all();
        tick();
        tick();

        // reset state
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_dec_pc", 64'(dec_pc), 64'd0);
        check("rst_dec_instr", 64'(dec_instr), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);

        // 1: short program ending in the sentinel
        fill_all();
        imem[0] = ADDI; imem[1] = ADD; imem[2] = LW; imem[3] = SW; imem[4] = 32'h0;
        fetch_en = 1'b1;
        dec_ready = 1'b1;
        do_reset();
        tick();
        check("t1_valid_c1", 64'(dec_valid), 64'd0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("t1_valid", 64'(dec_valid), 64'd1);
            check("t1_pc", 64'(dec_pc), 64'(4 * (c - 2)));
            if (c == 2) check("t1_instr0", 64'(dec_instr), 64'(ADDI));
        end
        check("t1_halt_c5", 64'(halted), 64'd0);
        tick();
        check("t1_halt_c6", 64'(halted), 64'd1);
        check("t1_empty_c6", 64'(dec_valid), 64'd0);
        check("t1_req_off", 64'(imem_req), 64'd0);
        check("t1_pc_hold", 64'(dec_pc), 64'd12);
        repeat (4) tick();
        check("t1_req_cnt", 64'(req_cnt), 64'd6);
        check("t1_max_addr", 64'(max_addr), 64'd20);
        check("t1_pop_cnt", 64'(pop_cnt), 64'd4);
        check("t1_pop_order", 64'(pop_bad), 64'd0);
        check("t1_instr", 64'(instr_bad), 64'd0);

        // 2: backpressure fills the queue, then drains without gaps
        fill_all();
        fetch_en = 1'b1;
        dec_ready = 1'b0;
        do_reset();
        check("t2_halt_clr", 64'(halted), 64'd0);
        repeat (5) tick();
        check("t2_pc_stall5", 64'(dec_pc), 64'd0);
        repeat (5) tick();
        check("t2_req_cnt", 64'(req_cnt), 64'd4);
        check("t2_instr_hold", 64'(dec_instr), 64'(imem[0]));
        dec_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("t2_valid", 64'(dec_valid), 64'd1);
            check("t2_pc", 64'(dec_pc), 64'(4 * k));
            tick();
        end
        check("t2_pop_order", 64'(pop_bad), 64'd0);

        // 3: alternating ready around a partly filled queue
        fill_all();
        fetch_en = 1'b1;
        dec_ready = 1'b0;
        do_reset();
        repeat (3) tick();
        check("t3_valid_c3", 64'(dec_valid), 64'd1);
        for (int c = 0; c < 40; c++) begin
            dec_ready = (c % 2 == 0);
            tick();
        end
        check("t3_pop_cnt", 64'(pop_cnt), 64'd20);
        check("t3_pop_order", 64'(pop_bad), 64'd0);
        check("t3_instr", 64'(instr_bad), 64'd0);
        check("t3_max_count", 64'(max_cnt <= 4), 64'd1);
        check("t3_issue_order", 64'(iss_bad), 64'd0);

        // 4: fetch_en low for three cycles mid-stream
        fill_all();
        fetch_en = 1'b1;
        dec_ready = 1'b1;
        do_reset();
        repeat (5) tick();
        fetch_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t4_req_off", 64'(imem_req), 64'd0);
            check("t4_pc_frozen", 64'(imem_addr), 64'd20);
            if (c == 2) check("t4_empty", 64'(dec_valid), 64'd0);
            tick();
        end
        check("t4_inflight_kept", 64'(pop_cnt), 64'd5);
        fetch_en = 1'b1;
        #1;
        check("t4_resume_req", 64'(imem_req), 64'd1);
        check("t4_resume_addr", 64'(imem_addr), 64'd20);
        repeat (6) tick();
        check("t4_issue_order", 64'(iss_bad), 64'd0);
        check("t4_pop_order", 64'(pop_bad), 64'd0);

        // 5: reset with three entries queued and one request inflight
        fill_all();
        fetch_en = 1'b1;
        dec_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        check("t5_pre_valid", 64'(dec_valid), 64'd1);
        rst = 1'b1;
        mon_clr = 1'b1;
        #1;
        check("t5_rst_valid", 64'(dec_valid), 64'd0);
        check("t5_rst_halted", 64'(halted), 64'd0);
        check("t5_rst_req", 64'(imem_req), 64'd0);
        tick();
        tick();
        mon_clr = 1'b0;
        rst = 1'b0;
        #1;
        check("t5_req_after", 64'(imem_req), 64'd1);
        check("t5_addr_after", 64'(imem_addr), 64'd0);
        tick();
        check("t5_valid_c1", 64'(dec_valid), 64'd0);
        tick();
        check("t5_valid_c2", 64'(dec_valid), 64'd1);
        check("t5_pc_c2", 64'(dec_pc), 64'd0);

        // 6: PC wraps through 0xFFC -> 0x000
        fill_all();
        fetch_en = 1'b1;
        dec_ready = 1'b1;
        do_reset();
        repeat (1030) tick();
        check("t6_req_cnt", 64'(req_cnt), 64'd1030);
        check("t6_issue_order", 64'(iss_bad), 64'd0);
        check("t6_wrap_seen", 64'(wrap_seen), 64'd1);
        check("t6_pop_cnt", 64'(pop_cnt), 64'd1028);
        check("t6_pop_order", 64'(pop_bad), 64'd0);
        check("t6_instr", 64'(instr_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
